fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end that drives the instruction memory and feeds decoded-stage input (IF/ID) through a small prefetch queue. It sequences the PC, tracks the one-cycle IM read latency, absorbs decode stalls, flushes on taken branches, and detects HLT so the core stops fetching cleanly. It sits directly upstream of the IF/ID pipeline register of the CPU core.

Parameters:
ADDR_W, 16, PC / IM address width
INST_W, 16, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_STEP, 1, PC increment per instruction
HLT_OP, 4'hF, opcode (instr[15:12]) treated as halt

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
im_addr  out  ADDR_W  IM read address (= fetch_pc)
im_rd_en  out  1  IM read request; data returns on im_instr next cycle
im_instr  in  INST_W  IM read data, valid the cycle after im_rd_en
id_ready  in  1  decode accepts head entry this cycle (low = stall)
if_valid  out  1  head entry valid
if_instr  out  INST_W  head instruction
if_pc_next  out  ADDR_W  head PC + PC_STEP (for branch-target calc)
br_taken  in  1  redirect request from EX
br_target  in  ADDR_W  redirect address
fetch_pc  out  ADDR_W  address of next request
hlt  out  1  sticky: HLT retired to decode and queue drained

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: fetch_pc=0, queue empty, inflight=0, state=FETCH, hlt=0, im_rd_en=0, if_valid=0; if_instr/if_pc_next drive 0 whenever if_valid=0.
- Internals: fetch_pc reg, inflight flag (request issued last cycle), occupancy counter 0..DEPTH, state {FETCH, DRAIN, HALTED}.
- Issue rule (combinational): im_rd_en = (state==FETCH) & (occupancy + inflight < DEPTH) & ~br_taken & ~(inflight & im_instr[15:12]==HLT_OP) & ~rst.
- On issue: fetch_pc <= fetch_pc + PC_STEP, mod 2^ADDR_W (FFFF -> 0000 wraps silently); inflight <= 1, else 0.
- Response: when inflight=1 and no br_taken, push {im_instr, request_pc + PC_STEP}. Latency: request cycle N -> if_valid earliest N+2.
- Pop: if_valid & id_ready removes head. Push and pop in the same cycle are legal at any occupancy; the credit rule guarantees no overflow.
- Redirect (br_taken=1 in cycle t) overrides everything: queue cleared, response arriving in t dropped, no issue in t, fetch_pc <= br_target, inflight <= 0, state <= FETCH unless HALTED. First request at br_target in t+1; if_valid at t+3. A pop in cycle t is ignored.
- Halt: a pushed response with opcode HLT_OP moves FETCH->DRAIN; no further requests. DRAIN->HALTED when the HLT entry is popped (queue empty after pop). hlt <= 1 on entry to HALTED. HALTED exits only via rst; br_taken is ignored in HALTED.
- Reset mid-operation: rst overrides redirect, push and pop; all state returns to reset values next edge.

Decomposition:
- Package fetch_pkg: state enum (FETCH, DRAIN, HALTED), HLT_OP default, queue entry typedef {instr, pc_next}, width constants.
- Sub-module fetch_queue: synchronous FIFO, DEPTH entries, push/pop/flush, occupancy output, flush has priority over push and pop.

Test Plan:
- Reset release, IM holds sequential ADD words at 0..7, id_ready=1 -> im_addr 0,1,2,... on consecutive cycles; if_valid first high 2 cycles after the first request; if_pc_next=1,2,3...
- id_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, im_rd_en low once occupancy+inflight=4; on release, order is preserved with no duplicates or drops.
- br_taken=1, br_target=16'h0040 with 3 entries queued and a response in flight -> if_valid=0 next cycle, im_addr=0x0040 at t+1, first if_instr = IM[0x40] at t+3.
- HLT at address 5 -> no request issued for address 6 or later; hlt=1 the cycle after the HLT entry pops; later br_taken has no effect.
- fetch_pc preset via br_target=16'hFFFF -> im_addr FFFF then 0000; if_pc_next for the FFFF entry = 0000.
- rst asserted while the queue is full and a request is in flight -> next cycle all outputs at reset values; refetch starts from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] HLT_OP_DEF = 4'hF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [ADDR_W-1:0] pc_next;
  } fetch_entry_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INST_W-1:0] instr);
    return instr[INST_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - IM, IF/ID and redirect signals of the fetch front end
interface fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] im_addr;
  logic              im_rd_en;
  logic [INST_W-1:0] im_instr;
  logic              id_ready;
  logic              if_valid;
  logic [INST_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc_next;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] fetch_pc;
  logic              hlt;

  modport master (
    output im_addr, im_rd_en, if_valid, if_instr, if_pc_next, fetch_pc, hlt,
    input  im_instr, id_ready, br_taken, br_target
  );

  modport slave (
    input  im_addr, im_rd_en, if_valid, if_instr, if_pc_next, fetch_pc, hlt,
    output im_instr, id_ready, br_taken, br_target
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO with flush, occupancy count and head output
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  fetch_entry_t      push_data_i,
  input  logic              pop_i,
  output fetch_entry_t      head_o,
  output logic [CNT_W-1:0]  count_o
);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer/occupancy next state; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents beyond the count are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, IM request credit, redirect and halt control
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH   = 4,
  parameter int              PC_STEP = 1,
  parameter logic [OP_W-1:0] HLT_OP  = HLT_OP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              hlt_q, hlt_d;

  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    credit_sum;
  fetch_entry_t      head, push_entry;
  logic              redirect, resp_is_hlt, has_credit;
  logic              issue, push, pop, if_valid;

  // A redirect in HALTED is ignored; the queue is already empty there.
  assign redirect    = bus.br_taken && (state_q != HALTED);
  // An HLT word on the return path blocks the request that would follow it.
  assign resp_is_hlt = inflight_q && (opcode_of(bus.im_instr) == HLT_OP);
  // Credit counts the in-flight response so the queue can never overflow.
  assign credit_sum  = {1'b0, occ} + (CNT_W + 1)'(inflight_q);
  assign has_credit  = credit_sum < (CNT_W + 1)'(DEPTH);

  assign issue    = (state_q == FETCH) && has_credit && !bus.br_taken && !resp_is_hlt && !rst;
  assign push     = inflight_q && !bus.br_taken;
  assign if_valid = (occ != '0);
  assign pop      = if_valid && bus.id_ready && !bus.br_taken;

  assign push_entry = '{instr: bus.im_instr, pc_next: req_pc_q + ADDR_W'(PC_STEP)};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.br_taken),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (occ)
  );

  // Next-state for the fetch FSM, PC, in-flight tracking and sticky halt.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    hlt_d      = hlt_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      req_pc_d   = fetch_pc_q;
    end

    case (state_q)
      FETCH:   if (push && (opcode_of(bus.im_instr) == HLT_OP)) state_d = DRAIN;
      DRAIN:   if (pop && !push && (occ == CNT_W'(1))) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase

    if (redirect) begin
      state_d    = FETCH;
      fetch_pc_d = bus.br_target;
    end

    if ((state_d == HALTED) && (state_q != HALTED)) hlt_d = 1'b1;
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // PC, request-address, in-flight and halt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      hlt_q      <= hlt_d;
    end
  end

  assign bus.im_addr    = fetch_pc_q;
  assign bus.fetch_pc   = fetch_pc_q;
  assign bus.im_rd_en   = issue;
  assign bus.if_valid   = if_valid;
  assign bus.if_instr   = if_valid ? head.instr   : '0;
  assign bus.if_pc_next = if_valid ? head.pc_next : '0;
  assign bus.hlt        = hlt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed stimulus with a queue-level reference model for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(4), .PC_STEP(1), .HLT_OP(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [0:65535];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one-cycle read latency.
  initial begin
    logic        pend;
    logic [15:0] pa;
    bus.im_instr = 16'h0;
    forever begin
      @(negedge clk);
      pend = bus.im_rd_en;
      pa   = bus.im_addr;
      @(posedge clk);
      #1;
      bus.im_instr = pend ? imem[pa] : 16'h0;
    end
  end

  // Reference model: a list of fetched words plus one pending read.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcn;
  } ment_t;

  ment_t       mq[$];
  logic [15:0] m_pc, m_pa, pw;
  bit          m_pend, m_hlt, model_ok, popped;
  int          mode;
  bit          e_valid, e_rd;
  logic [15:0] e_instr, e_pcn;

  initial begin
    model_ok = 1'b0;
    m_pend = 1'b0;
    m_hlt = 1'b0;
    mode = 0;
    m_pc = 16'h0;
    m_pa = 16'h0;
  end

  always @(negedge clk) begin
    e_valid = (mq.size() > 0);
    e_instr = 16'h0;
    e_pcn   = 16'h0;
    if (e_valid) begin
      e_instr = mq[0].instr;
      e_pcn   = mq[0].pcn;
    end
    pw   = imem[m_pa];
    e_rd = !rst && (mode == 0) && ((mq.size() + int'(m_pend)) < 4) && !bus.br_taken
           && !(m_pend && (pw[15:12] == 4'hF));

    if (model_ok) begin
      chk("m_im_rd_en",   bus.im_rd_en,   e_rd);
      chk("m_im_addr",    bus.im_addr,    m_pc);
      chk("m_fetch_pc",   bus.fetch_pc,   m_pc);
      chk("m_if_valid",   bus.if_valid,   e_valid);
      chk("m_if_instr",   bus.if_instr,   e_instr);
      chk("m_if_pc_next", bus.if_pc_next, e_pcn);
      chk("m_hlt",        bus.hlt,        m_hlt);
    end

    if (rst) begin
      mq.delete();
      m_pc = 16'h0;
      m_pend = 1'b0;
      mode = 0;
      m_hlt = 1'b0;
      model_ok = 1'b1;
    end else if (bus.br_taken && mode != 2) begin
      mq.delete();
      m_pc = bus.br_target;
      m_pend = 1'b0;
      mode = 0;
    end else begin
      popped = 1'b0;
      if (mq.size() > 0 && bus.id_ready) begin
        void'(mq.pop_front());
        popped = 1'b1;
      end
      if (m_pend) begin
        mq.push_back('{instr: pw, pcn: m_pa + 16'd1});
        if (pw[15:12] == 4'hF && mode == 0) mode = 1;
      end
      if (popped && mode == 1 && mq.size() == 0) begin
        mode = 2;
        m_hlt = 1'b1;
      end
      if (e_rd) begin
        m_pa = m_pc;
        m_pc = m_pc + 16'd1;
      end
      m_pend = e_rd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    for (int a = 0; a < 65536; a++) imem[a] = {4'h1, a[11:0]};
    rst = 1'b1;
    bus.id_ready = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 16'h0;

    step(); #3;
    chk("rst_rd_en",   bus.im_rd_en,   0);
    chk("rst_valid",   bus.if_valid,   0);
    chk("rst_pc",      bus.fetch_pc,   0);
    chk("rst_hlt",     bus.hlt,        0);
    chk("rst_instr",   bus.if_instr,   0);
    chk("rst_pc_next", bus.if_pc_next, 0);

    step(); rst = 1'b0; #3;
    chk("c0_rd_en", bus.im_rd_en, 1);
    chk("c0_addr",  bus.im_addr,  16'h0000);
    step();
    step(); #3;
    chk("c2_valid",   bus.if_valid,   1);
    chk("c2_instr",   bus.if_instr,   16'h1000);
    chk("c2_pc_next", bus.if_pc_next, 16'h0001);
    chk("c2_addr",    bus.im_addr,    16'h0002);
    step(); #3;
    chk("c3_instr",   bus.if_instr,   16'h1001);
    chk("c3_pc_next", bus.if_pc_next, 16'h0002);
    step();
    step();

    step(); bus.id_ready = 1'b0;
    repeat (9) step();
    #3;
    chk("stall_rd_en", bus.im_rd_en, 0);
    chk("stall_head",  bus.if_instr, 16'h1004);
    chk("stall_pc",    bus.fetch_pc, 16'h0008);
    step(); bus.id_ready = 1'b1; #3;
    chk("rel0_head",  bus.if_instr, 16'h1004);
    chk("rel0_rd_en", bus.im_rd_en, 0);
    step(); #3;
    chk("rel1_head",  bus.if_instr, 16'h1005);
    chk("rel1_addr",  bus.im_addr,  16'h0008);
    chk("rel1_rd_en", bus.im_rd_en, 1);
    step();
    step(); #3;
    chk("rel3_head", bus.if_instr, 16'h1007);
    step();

    step(); bus.id_ready = 1'b0;
    step(); bus.id_ready = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0040; #3;
    chk("br_t_valid", bus.if_valid, 1);
    chk("br_t_rd_en", bus.im_rd_en, 0);
    step(); bus.br_taken = 1'b0; #3;
    chk("br_t1_valid", bus.if_valid, 0);
    chk("br_t1_addr",  bus.im_addr,  16'h0040);
    chk("br_t1_rd_en", bus.im_rd_en, 1);
    step(); #3;
    chk("br_t2_valid", bus.if_valid, 0);
    step(); #3;
    chk("br_t3_valid",   bus.if_valid,   1);
    chk("br_t3_instr",   bus.if_instr,   16'h1040);
    chk("br_t3_pc_next", bus.if_pc_next, 16'h0041);
    step();

    step(); bus.br_taken = 1'b1; bus.br_target = 16'hFFFF;
    step(); bus.br_taken = 1'b0; #3;
    chk("wrap_addr0", bus.im_addr,  16'hFFFF);
    chk("wrap_rd_en", bus.im_rd_en, 1);
    step(); #3;
    chk("wrap_addr1", bus.im_addr, 16'h0000);
    step(); #3;
    chk("wrap_instr",   bus.if_instr,   16'h1FFF);
    chk("wrap_pc_next", bus.if_pc_next, 16'h0000);
    step(); #3;
    chk("wrap2_instr",   bus.if_instr,   16'h1000);
    chk("wrap2_pc_next", bus.if_pc_next, 16'h0001);

    step(); bus.id_ready = 1'b0;
    repeat (5) step();
    #3;
    chk("full_rd_en", bus.im_rd_en, 0);
    chk("full_head",  bus.if_instr, 16'h1001);
    step(); rst = 1'b1; imem[5] = 16'hF005;
    step(); #3;
    chk("mrst_valid",   bus.if_valid,   0);
    chk("mrst_rd_en",   bus.im_rd_en,   0);
    chk("mrst_pc",      bus.fetch_pc,   0);
    chk("mrst_hlt",     bus.hlt,        0);
    chk("mrst_instr",   bus.if_instr,   0);
    chk("mrst_pc_next", bus.if_pc_next, 0);
    step(); rst = 1'b0; bus.id_ready = 1'b1; #3;
    chk("refetch_rd_en", bus.im_rd_en, 1);
    chk("refetch_addr",  bus.im_addr,  16'h0000);

    repeat (6) step();
    #3;
    chk("hlt_blk_rd_en", bus.im_rd_en, 0);
    chk("hlt_blk_pc",    bus.fetch_pc, 16'h0006);
    chk("hlt_blk_head",  bus.if_instr, 16'h1004);
    step(); #3;
    chk("hlt_head",  bus.if_instr, 16'hF005);
    chk("hlt_pre",   bus.hlt,      0);
    chk("hlt_rd_en", bus.im_rd_en, 0);
    step(); #3;
    chk("hlt_set",   bus.hlt,      1);
    chk("hlt_valid", bus.if_valid, 0);
    step(); bus.br_taken = 1'b1; bus.br_target = 16'h0040;
    step(); bus.br_taken = 1'b0; #3;
    chk("hlt_br_pc",    bus.fetch_pc, 16'h0006);
    chk("hlt_br_hlt",   bus.hlt,      1);
    chk("hlt_br_rd_en", bus.im_rd_en, 0);
    chk("hlt_br_valid", bus.if_valid, 0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
